// File: rtl/bmu_pkg.sv
// BMU shared types: one-hot ap control struct, 5-bit opcode enum and the
// opcode -> ap decode used by the issuer.
package bmu_pkg;

  localparam int BMU_NUM_OPS = 18;

  typedef enum logic [4:0] {
    OP_ADD     = 5'd0,
    OP_SUB     = 5'd1,
    OP_SLT     = 5'd2,
    OP_AND     = 5'd3,
    OP_XOR     = 5'd4,
    OP_SLL     = 5'd5,
    OP_SRA     = 5'd6,
    OP_ROL     = 5'd7,
    OP_BEXT    = 5'd8,
    OP_SH3ADD  = 5'd9,
    OP_CLZ     = 5'd10,
    OP_CPOP    = 5'd11,
    OP_SIEXT_H = 5'd12,
    OP_MIN     = 5'd13,
    OP_PACKU   = 5'd14,
    OP_GORC    = 5'd15,
    OP_CSRW    = 5'd16,
    OP_CSRWI   = 5'd17
  } bmu_op_e;

  // 22 bits, csr_write is the MSB and gorc the LSB.
  typedef struct packed {
    logic csr_write;
    logic csr_imm;
    logic zbb;
    logic zbs;
    logic zba;
    logic zbp;
    logic add;
    logic sub;
    logic slt;
    logic land;
    logic lxor;
    logic sll;
    logic sra;
    logic rol;
    logic bext;
    logic sh3add;
    logic clz;
    logic cpop;
    logic siext_h;
    logic min;
    logic packu;
    logic gorc;
  } bmu_ap_t;

  function automatic bmu_ap_t bmu_op_decode(bmu_op_e op);
    bmu_ap_t ap;
    ap = '0;
    unique case (op)
      OP_ADD:     ap.add = 1'b1;
      OP_SUB:     ap.sub = 1'b1;
      OP_SLT:     ap.slt = 1'b1;
      OP_AND:     ap.land = 1'b1;
      OP_XOR:     ap.lxor = 1'b1;
      OP_SLL:     ap.sll = 1'b1;
      OP_SRA:     ap.sra = 1'b1;
      OP_ROL:     begin ap.rol = 1'b1; ap.zbb = 1'b1; end
      OP_BEXT:    begin ap.bext = 1'b1; ap.zbs = 1'b1; end
      OP_SH3ADD:  begin ap.sh3add = 1'b1; ap.zba = 1'b1; end
      OP_CLZ:     begin ap.clz = 1'b1; ap.zbb = 1'b1; end
      OP_CPOP:    begin ap.cpop = 1'b1; ap.zbb = 1'b1; end
      OP_SIEXT_H: begin ap.siext_h = 1'b1; ap.zbb = 1'b1; end
      OP_MIN:     begin ap.min = 1'b1; ap.zbb = 1'b1; end
      OP_PACKU:   begin ap.packu = 1'b1; ap.zbp = 1'b1; end
      OP_GORC:    begin ap.gorc = 1'b1; ap.zbp = 1'b1; end
      OP_CSRW:    ap.csr_write = 1'b1;
      OP_CSRWI:   begin ap.csr_write = 1'b1; ap.csr_imm = 1'b1; end
      default:    ap = '0;
    endcase
    return ap;
  endfunction

endpackage

// File: rtl/bmu_rsp_fifo.sv
// Response FIFO: DEPTH x W entries, push/pop same cycle allowed, rdata is 0
// while empty. Ports: clk, rst, push, wdata, pop, rdata, empty, full.
module bmu_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 37
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_pop;

  assign empty  = (cnt_q == '0);
  assign full   = (cnt_q == FULL_CNT);
  assign do_pop = pop & ~empty;
  assign rdata  = empty ? '0 : mem_q[rd_q];

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push) wr_d = wr_q + 1'b1;
    if (do_pop) rd_d = rd_q + 1'b1;
    unique case ({push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= wdata;
  end

  // Credit accounting upstream makes a push into a full FIFO unreachable.
  a_no_ovf: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/bmu_op_issuer.sv
// BMU initiator: accepts tagged commands, drives one-cycle BMU requests,
// captures result/error after LATENCY and returns in-order tagged responses.
// Ports: cmd_* (in, valid/ready), bmu_* (to/from BMU), rsp_* (out, valid/ready).
// Optional: define BMU_OP_ISSUER_ERRCNT_EN to add err_cnt[15:0] (saturating
// count of error responses handed off).
module bmu_op_issuer
  import bmu_pkg::*;
#(
  parameter int TAG_W   = 4,
  parameter int DEPTH   = 4,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [4:0]       cmd_op,
  input  logic [31:0]      cmd_a,
  input  logic [31:0]      cmd_b,
  input  logic             cmd_csr_ren,
  input  logic [31:0]      cmd_csr_rddata,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic             bmu_valid_in,
  output logic [31:0]      bmu_a_in,
  output logic [31:0]      bmu_b_in,
  output logic [21:0]      bmu_ap,
  output logic             bmu_csr_ren_in,
  output logic [31:0]      bmu_csr_rddata_in,
  input  logic [31:0]      bmu_result_ff,
  input  logic             bmu_error,
`ifdef BMU_OP_ISSUER_ERRCNT_EN
  output logic [15:0]      err_cnt,
`endif
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [31:0]      rsp_result,
  output logic             rsp_error
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int FW = TAG_W + 33;

  logic          acc, rsp_hs, illegal;
  logic [CW-1:0] credit_q, credit_d;
  logic          rdy_q, rdy_d;

  logic          bv_q, bv_d;
  logic [31:0]   a_q, a_d, b_q, b_d;
  bmu_ap_t       ap_q, ap_d;
  logic          ren_q, ren_d;
  logic [31:0]   rdd_q, rdd_d;

  logic             iss_vld_q, iss_vld_d;
  logic             iss_ill_q, iss_ill_d;
  logic [TAG_W-1:0] iss_tag_q, iss_tag_d;

  logic [LATENCY-1:0]            dl_vld_q, dl_vld_d;
  logic [LATENCY-1:0]            dl_ill_q, dl_ill_d;
  logic [LATENCY-1:0][TAG_W-1:0] dl_tag_q, dl_tag_d;

  logic          push, f_empty, f_full;
  logic          cap_ill;
  logic [FW-1:0] f_wdata, f_rdata;

  assign acc     = cmd_valid & rdy_q;
  assign rsp_hs  = rsp_valid & rsp_ready;
  assign illegal = (cmd_op >= 5'(BMU_NUM_OPS));

  assign cmd_ready         = rdy_q;
  assign bmu_valid_in      = bv_q;
  assign bmu_a_in          = a_q;
  assign bmu_b_in          = b_q;
  assign bmu_ap            = ap_q;
  assign bmu_csr_ren_in    = ren_q;
  assign bmu_csr_rddata_in = rdd_q;

  always_comb begin
    credit_d = credit_q;
    unique case ({acc, rsp_hs})
      2'b10:   credit_d = credit_q + 1'b1;
      2'b01:   credit_d = credit_q - 1'b1;
      default: credit_d = credit_q;
    endcase
    rdy_d = (credit_d < CW'(DEPTH));
  end

  // Illegal ops keep the BMU bus idle but still occupy a delay-line slot.
  always_comb begin
    bv_d  = 1'b0;
    a_d   = '0;
    b_d   = '0;
    ap_d  = '0;
    ren_d = 1'b0;
    rdd_d = '0;
    if (acc && !illegal) begin
      bv_d  = 1'b1;
      a_d   = cmd_a;
      b_d   = cmd_b;
      ap_d  = bmu_op_decode(bmu_op_e'(cmd_op));
      ren_d = cmd_csr_ren;
      rdd_d = cmd_csr_rddata;
    end
    iss_vld_d = acc;
    iss_ill_d = acc & illegal;
    iss_tag_d = acc ? cmd_tag : '0;
  end

  always_comb begin
    dl_vld_d    = '0;
    dl_ill_d    = '0;
    dl_tag_d    = '0;
    dl_vld_d[0] = iss_vld_q;
    dl_ill_d[0] = iss_ill_q;
    dl_tag_d[0] = iss_tag_q;
    for (int i = 1; i < LATENCY; i++) begin
      dl_vld_d[i] = dl_vld_q[i-1];
      dl_ill_d[i] = dl_ill_q[i-1];
      dl_tag_d[i] = dl_tag_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credit_q  <= '0;
      rdy_q     <= 1'b0;
      bv_q      <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      ap_q      <= '0;
      ren_q     <= 1'b0;
      rdd_q     <= '0;
      iss_vld_q <= 1'b0;
      iss_ill_q <= 1'b0;
      iss_tag_q <= '0;
      dl_vld_q  <= '0;
      dl_ill_q  <= '0;
      dl_tag_q  <= '0;
    end else begin
      credit_q  <= credit_d;
      rdy_q     <= rdy_d;
      bv_q      <= bv_d;
      a_q       <= a_d;
      b_q       <= b_d;
      ap_q      <= ap_d;
      ren_q     <= ren_d;
      rdd_q     <= rdd_d;
      iss_vld_q <= iss_vld_d;
      iss_ill_q <= iss_ill_d;
      iss_tag_q <= iss_tag_d;
      dl_vld_q  <= dl_vld_d;
      dl_ill_q  <= dl_ill_d;
      dl_tag_q  <= dl_tag_d;
    end
  end

  assign push    = dl_vld_q[LATENCY-1];
  assign cap_ill = dl_ill_q[LATENCY-1];
  assign f_wdata = {dl_tag_q[LATENCY-1],
                    cap_ill ? 32'd0 : bmu_result_ff,
                    cap_ill | bmu_error};

  bmu_rsp_fifo #(
    .DEPTH (DEPTH),
    .W     (FW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (f_wdata),
    .pop   (rsp_ready),
    .rdata (f_rdata),
    .empty (f_empty),
    .full  (f_full)
  );

  assign rsp_valid = ~f_empty;
  assign {rsp_tag, rsp_result, rsp_error} = f_rdata;

`ifdef BMU_OP_ISSUER_ERRCNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (rsp_hs && rsp_error && (err_cnt_q != 16'hFFFF))
      err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_cnt_q <= '0;
    else     err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_bmu_op_issuer.sv
// Directed bench for bmu_op_issuer with a LATENCY=1 BMU stub.
// Inputs are driven and outputs sampled on the falling edge.
module tb_bmu_op_issuer;
  import bmu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [4:0]  cmd_op = '0;
  logic [31:0] cmd_a = '0;
  logic [31:0] cmd_b = '0;
  logic        cmd_csr_ren = 1'b0;
  logic [31:0] cmd_csr_rddata = '0;
  logic [3:0]  cmd_tag = '0;
  logic        bmu_valid_in;
  logic [31:0] bmu_a_in, bmu_b_in;
  logic [21:0] bmu_ap;
  logic        bmu_csr_ren_in;
  logic [31:0] bmu_csr_rddata_in;
  logic [31:0] bmu_result_ff = '0;
  logic        bmu_error = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [3:0]  rsp_tag;
  logic [31:0] rsp_result;
  logic        rsp_error;
`ifdef BMU_OP_ISSUER_ERRCNT_EN
  logic [15:0] err_cnt;
`endif

  logic err_inj = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  bmu_op_issuer #(.TAG_W(4), .DEPTH(4), .LATENCY(1)) dut (
    .clk               (clk),
    .rst               (rst),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .cmd_op            (cmd_op),
    .cmd_a             (cmd_a),
    .cmd_b             (cmd_b),
    .cmd_csr_ren       (cmd_csr_ren),
    .cmd_csr_rddata    (cmd_csr_rddata),
    .cmd_tag           (cmd_tag),
    .bmu_valid_in      (bmu_valid_in),
    .bmu_a_in          (bmu_a_in),
    .bmu_b_in          (bmu_b_in),
    .bmu_ap            (bmu_ap),
    .bmu_csr_ren_in    (bmu_csr_ren_in),
    .bmu_csr_rddata_in (bmu_csr_rddata_in),
    .bmu_result_ff     (bmu_result_ff),
    .bmu_error         (bmu_error),
`ifdef BMU_OP_ISSUER_ERRCNT_EN
    .err_cnt           (err_cnt),
`endif
    .rsp_valid         (rsp_valid),
    .rsp_ready         (rsp_ready),
    .rsp_tag           (rsp_tag),
    .rsp_result        (rsp_result),
    .rsp_error         (rsp_error)
  );

  // BMU stub: subtract when the sub bit (14) is set, otherwise add.
  always @(posedge clk) begin
    bmu_result_ff <= bmu_ap[14] ? bmu_a_in - bmu_b_in : bmu_a_in + bmu_b_in;
    bmu_error     <= bmu_valid_in & err_inj;
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [4:0] op, input logic [3:0] t,
                      input logic [31:0] a, input logic [31:0] b);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_tag   = t;
    cmd_a     = a;
    cmd_b     = b;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic pop_exp(input logic [3:0] t, input logic [31:0] r,
                         input logic e);
    int n;
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("pop_vld", rsp_valid, 1);
    chk("pop_tag", rsp_tag, t);
    chk("pop_res", rsp_result, r);
    chk("pop_err", rsp_error, e);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  logic [21:0] dec_exp [3];
  logic [4:0]  dec_op  [3];

  initial begin
    dec_op[0] = 5'd9;  dec_exp[0] = 22'h020040;
    dec_op[1] = 5'd10; dec_exp[1] = 22'h080020;
    dec_op[2] = 5'd17; dec_exp[2] = 22'h300000;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_rdy", cmd_ready, 0);
    chk("rst_rvld", rsp_valid, 0);
    chk("rst_bvld", bmu_valid_in, 0);
    chk("rst_rtag", rsp_tag, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rdy_up", cmd_ready, 1);

    // 1: ADD 5+7 tag 3
    send(5'd0, 4'd3, 32'd5, 32'd7);
    chk("t1_bvld", bmu_valid_in, 1);
    chk("t1_ap", bmu_ap, 22'h008000);
    chk("t1_a", bmu_a_in, 5);
    chk("t1_b", bmu_b_in, 7);
    chk("t1_rvld0", rsp_valid, 0);
    @(negedge clk);
    chk("t1_bidle", bmu_valid_in, 0);
    chk("t1_aidle", bmu_a_in, 0);
    chk("t1_rvld1", rsp_valid, 0);
    @(negedge clk);
    chk("t1_lat", rsp_valid, 1);
    pop_exp(4'd3, 32'd12, 1'b0);
    chk("t1_empty", rsp_valid, 0);

    // 2: four SUBs, credit stall, in-order drain
    for (int i = 0; i < 4; i++) begin
      send(5'd1, 4'(i), 32'(10 + i), 32'd1);
      if (i == 0) chk("t2_ap", bmu_ap, 22'h004000);
    end
    chk("t2_full", cmd_ready, 0);
    repeat (4) @(negedge clk);
    chk("t2_hold_t", rsp_tag, 0);
    @(negedge clk);
    chk("t2_stab_t", rsp_tag, 0);
    chk("t2_stab_r", rsp_result, 9);
    chk("t2_still", cmd_ready, 0);
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("t2_vld", rsp_valid, 1);
      chk("t2_tag", rsp_tag, 4'(k));
      chk("t2_res", rsp_result, 32'(9 + k));
      if (k == 1) chk("t2_rdy", cmd_ready, 1);
      @(negedge clk);
    end
    chk("t2_empty", rsp_valid, 0);
    rsp_ready = 1'b0;

    // 3: illegal opcode 31
    send(5'd31, 4'd9, 32'd1, 32'd2);
    chk("t3_bvld", bmu_valid_in, 0);
    chk("t3_ap", bmu_ap, 0);
    @(negedge clk);
    chk("t3_bvld2", bmu_valid_in, 0);
    chk("t3_rvld0", rsp_valid, 0);
    @(negedge clk);
    chk("t3_lat", rsp_valid, 1);
    pop_exp(4'd9, 32'd0, 1'b1);

    // 4: reset with two ops in flight
    send(5'd0, 4'd5, 32'd1, 32'd1);
    send(5'd0, 4'd6, 32'd2, 32'd2);
    rst = 1'b1;
    #1;
    chk("t4_rvld", rsp_valid, 0);
    chk("t4_rdy", cmd_ready, 0);
    chk("t4_bvld", bmu_valid_in, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("t4_norsp", rsp_valid, 0);
    end
    chk("t4_rdy2", cmd_ready, 1);

    // 5: credits at 3, accept and pop in the same cycle
    for (int i = 1; i <= 3; i++) send(5'd0, 4'(i), 32'(i), 32'd1);
    repeat (4) @(negedge clk);
    chk("t5_rdy3", cmd_ready, 1);
    chk("t5_head", rsp_tag, 1);
    chk("t5_hres", rsp_result, 2);
    cmd_valid = 1'b1; cmd_op = 5'd0; cmd_tag = 4'd4;
    cmd_a = 32'd4; cmd_b = 32'd1;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("t5_rdy_kept", cmd_ready, 1);
    cmd_tag = 4'd5; cmd_a = 32'd5;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("t5_rdy_full", cmd_ready, 0);
    pop_exp(4'd2, 32'd3, 1'b0);
    pop_exp(4'd3, 32'd4, 1'b0);
    pop_exp(4'd4, 32'd5, 1'b0);
    pop_exp(4'd5, 32'd6, 1'b0);

    // BMU error flag passes through
    err_inj = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(5'd0, 4'(7 + i), 32'd1, 32'(i));
      pop_exp(4'(7 + i), 32'(1 + i), 1'b1);
    end
    err_inj = 1'b0;
`ifdef BMU_OP_ISSUER_ERRCNT_EN
    chk("errcnt", err_cnt, 16'd3);
`endif

    // decode spot checks with csr pass-through
    for (int i = 0; i < 3; i++) begin
      cmd_csr_ren    = 1'b1;
      cmd_csr_rddata = 32'hCAFE0000 + 32'(i);
      send(dec_op[i], 4'(10 + i), 32'(i), 32'd100);
      cmd_csr_ren = 1'b0;
      chk("dec_bvld", bmu_valid_in, 1);
      chk("dec_ap", bmu_ap, dec_exp[i]);
      chk("dec_ren", bmu_csr_ren_in, 1);
      chk("dec_rdd", bmu_csr_rddata_in, 32'hCAFE0000 + 32'(i));
      pop_exp(4'(10 + i), 32'(100 + i), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
